// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store per handshake, waits WAIT_CYC cycles,
// merges/extracts byte lanes and pulses a response. Optional DM_MISALIGN_CHK_EN rejects misaligned accesses.
module dm_responder #(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_storewhb,
   input  logic [2:0]  req_loadwhb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
   localparam bit         NO_WAIT   = (WAIT_CYC == 0);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              a_we;
   logic [ADDR_W+1:0] a_addr;
   logic [31:0]       a_wdata;
   logic [1:0]        a_sw;
   logic [2:0]        a_lw;

   logic              c_we;
   logic [ADDR_W+1:0] c_addr;
   logic [31:0]       c_wdata;
   logic [1:0]        c_sw;
   logic [2:0]        c_lw;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        off;

   logic              to_resp, err, misalign, wr_en, unused_addr;
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic [31:0]       rd_word, wr_word, wr_rep, ld_data;
   logic [3:0]        be;
   logic [15:0]       half;
   logic [7:0]        byt;

   assign req_ready   = (state == S_IDLE);
   assign rsp_valid   = (state == S_RESP);
   assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

   // With zero wait the accept edge is also the RESP-entry edge, so decode the live inputs in IDLE.
   assign c_we    = req_ready ? req_we                  : a_we;
   assign c_addr  = req_ready ? req_addr[ADDR_W+1:0]    : a_addr;
   assign c_wdata = req_ready ? req_wdata               : a_wdata;
   assign c_sw    = req_ready ? req_storewhb            : a_sw;
   assign c_lw    = req_ready ? req_loadwhb             : a_lw;
   assign idx     = c_addr[ADDR_W+1:2];
   assign off     = c_addr[1:0];
   assign rd_word = mem[idx];

   assign to_resp = (req_ready & req_valid & NO_WAIT) | ((state == S_WAIT) & (cnt == 4'd1));

   always_comb begin
      misalign = 1'b0;
`ifdef DM_MISALIGN_CHK_EN
      if (c_we) misalign = ((c_sw == 2'b00) & (off != 2'b00)) | ((c_sw == 2'b01) & off[0]);
      else      misalign = ((c_lw == 3'd0) & (off != 2'b00)) |
                           (((c_lw == 3'd1) | (c_lw == 3'd2)) & off[0]);
`endif
      err = (c_we ? (c_sw == 2'b11) : (c_lw > 3'd4)) | misalign;
   end

   // Store: replicate the operand across lanes and merge under a byte enable.
   always_comb begin
      be     = 4'b0000;
      wr_rep = c_wdata;
      case (c_sw)
         2'b00:   be = 4'b1111;
         2'b01: begin
            be     = off[1] ? 4'b1100 : 4'b0011;
            wr_rep = {2{c_wdata[15:0]}};
         end
         2'b10: begin
            be     = 4'b0001 << off;
            wr_rep = {4{c_wdata[7:0]}};
         end
         default: be = 4'b0000;
      endcase
      wr_word = rd_word;
      for (int i = 0; i < 4; i++)
         if (be[i]) wr_word[8*i +: 8] = wr_rep[8*i +: 8];
   end

   always_comb begin
      half = off[1] ? rd_word[31:16] : rd_word[15:0];
      byt  = rd_word[{off, 3'b000} +: 8];
      case (c_lw)
         3'd0:    ld_data = rd_word;
         3'd1:    ld_data = {{16{half[15]}}, half};
         3'd2:    ld_data = {16'h0000, half};
         3'd3:    ld_data = {{24{byt[7]}}, byt};
         3'd4:    ld_data = {24'h000000, byt};
         default: ld_data = 32'h0;
      endcase
   end

   // rst gates the write so a reset coincident with the RESP-entry edge commits nothing.
   assign wr_en = to_resp & c_we & ~err & ~rst;

   always_ff @(posedge clk)
      if (wr_en) mem[idx] <= wr_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         a_we      <= 1'b0;
         a_addr    <= '0;
         a_wdata   <= 32'h0;
         a_sw      <= 2'b00;
         a_lw      <= 3'd0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               a_we    <= req_we;
               a_addr  <= req_addr[ADDR_W+1:0];
               a_wdata <= req_wdata;
               a_sw    <= req_storewhb;
               a_lw    <= req_loadwhb;
               cnt     <= WAIT_INIT;
               state   <= NO_WAIT ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            default: state <= S_IDLE;
         endcase
         if (to_resp) begin
            rsp_err   <= err;
            rsp_rdata <= (c_we | err) ? 32'h0 : ld_data;
         end
      end
   end
endmodule

// File: tb/tb_dm_responder.sv
// Randomized check of dm_responder against a byte-addressed memory model; a second
// zero-wait instance covers back-to-back handshakes.
module tb_dm_responder;
   localparam int WAIT = 2;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_storewhb = '0;
   logic [2:0]  req_loadwhb = '0;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        z_valid = 1'b0, z_ready, z_we = 1'b0;
   logic [31:0] z_addr = '0, z_wdata = '0;
   logic [1:0]  z_sw = '0;
   logic [2:0]  z_lw = '0;
   logic        z_rsp_valid, z_rsp_err;
   logic [31:0] z_rsp_rdata;

   int n_cmp = 0, n_bad = 0;
   logic [7:0] mb [0:4095];

   always #5 clk = ~clk;

   dm_responder #(.ADDR_W(10), .WAIT_CYC(WAIT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_storewhb(req_storewhb),
      .req_loadwhb(req_loadwhb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   dm_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
      .req_addr(z_addr), .req_wdata(z_wdata), .req_storewhb(z_sw),
      .req_loadwhb(z_lw), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   // Reference: memory as 4 KiB of bytes; an access is a naturally sized run of bytes.
   task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] sw, input logic [2:0] lw,
                        output logic [31:0] rd, output logic er);
      int a, size;
      logic [31:0] v;
      a    = int'(addr % 4096);
      size = we ? (sw == 0 ? 4 : sw == 1 ? 2 : 1) : (lw == 0 ? 4 : lw < 3 ? 2 : 1);
      er   = we ? (sw == 3) : (lw > 4);
`ifdef DM_MISALIGN_CHK_EN
      if (a % size != 0) er = 1'b1;
`endif
      a  = a - a % size;
      rd = 32'h0;
      v  = 32'h0;
      if (!er) begin
         if (we) for (int k = 0; k < size; k++) mb[a+k] = wdata[8*k +: 8];
         else begin
            for (int k = 0; k < size; k++) v = v | (32'(mb[a+k]) << (8*k));
            case (lw)
               3'd1:    rd = (v >= 32'h8000) ? v - 32'h10000 : v;
               3'd3:    rd = (v >= 32'h80)   ? v - 32'h100   : v;
               default: rd = v;
            endcase
         end
      end
   endtask

   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] sw, input logic [2:0] lw,
                       output logic [31:0] rd, output logic er);
      logic [31:0] erd;
      logic        eer;
      int          n;
      model(we, addr, wdata, sw, lw, erd, eer);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_storewhb = sw; req_loadwhb = lw;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk("ready_before_accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      // Scramble the bus after accept: the responder must work from its latched copy.
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_storewhb = 2'($urandom); req_loadwhb = 3'($urandom);
      n = 1;
      while (!rsp_valid && n < 20) begin
         chk("ready_low_busy", 32'(req_ready), 32'd0);
         @(negedge clk); n++;
      end
      chk("latency", 32'(n), 32'(WAIT + 1));
      chk("rdata", rsp_rdata, erd);
      chk("err", 32'(rsp_err), 32'(eer));
      rd = rsp_rdata; er = rsp_err;
      @(negedge clk);
      chk("single_pulse", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a;
      logic        er, seen;
      int          pulses;

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;

      xact(1, 32'h10, 32'hDEADBEEF, 0, 0, rd, er);
      chk("sw_err", 32'(er), 32'd0);
      xact(0, 32'h10, 0, 0, 0, rd, er);
      chk("lw_deadbeef", rd, 32'hDEADBEEF);

      xact(1, 32'h20, 32'h11223344, 0, 0, rd, er);
      xact(1, 32'h21, 32'h000000AA, 2, 0, rd, er);
      xact(1, 32'h22, 32'h00005566, 1, 0, rd, er);
      xact(0, 32'h20, 0, 0, 0, rd, er);
      chk("merge", rd, 32'h5566AA44);

      xact(1, 32'h30, 32'h80FF7F01, 0, 0, rd, er);
      xact(0, 32'h32, 0, 0, 3, rd, er); chk("lb_32", rd, 32'hFFFFFFFF);
      xact(0, 32'h32, 0, 0, 4, rd, er); chk("lbu_32", rd, 32'h000000FF);
      xact(0, 32'h32, 0, 0, 1, rd, er); chk("lh_32", rd, 32'hFFFF80FF);
      xact(0, 32'h30, 0, 0, 2, rd, er); chk("lhu_30", rd, 32'h00007F01);
      xact(0, 32'h30, 0, 0, 3, rd, er); chk("lb_30", rd, 32'h00000001);

      xact(1, 32'h0000_1010, 32'hCAFEF00D, 0, 0, rd, er);
      xact(0, 32'h10, 0, 0, 0, rd, er); chk("addr_wrap", rd, 32'hCAFEF00D);
      xact(1, 32'h10, 32'h99, 3, 0, rd, er);
      chk("rsvd_store_err", 32'(er), 32'd1);
      xact(0, 32'h10, 0, 0, 0, rd, er); chk("rsvd_store_nowrite", rd, 32'hCAFEF00D);
      xact(0, 32'h10, 0, 0, 5, rd, er);
      chk("rsvd_load_err", 32'(er), 32'd1);
      chk("rsvd_load_rdata", rd, 32'h0);

      // Reset during WAIT aborts the store.
      xact(1, 32'h40, 32'h0, 0, 0, rd, er);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678;
      req_storewhb = 2'b00;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("midop_in_wait", 32'(req_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      chk("midop_no_rsp", 32'(seen), 32'd0);
      xact(0, 32'h40, 0, 0, 0, rd, er); chk("midop_no_write", rd, 32'h0);

      xact(1, 32'h41, 32'h0000BEEF, 1, 0, rd, er);
      xact(0, 32'h40, 0, 0, 0, rd, er);
`ifdef DM_MISALIGN_CHK_EN
      chk("misalign_sh_word", rd, 32'h0);
`else
      chk("misalign_sh_word", rd, 32'h0000BEEF);
`endif

      for (int w = 0; w < 64; w++) xact(1, 32'h100 + 32'(4*w), $urandom, 0, 0, rd, er);
      for (int i = 0; i < 150; i++) begin
         a = $urandom;
         a[11:0] = 12'h100 + 12'($urandom_range(0, 255));
         xact(1'($urandom), a, $urandom, 2'($urandom), 3'($urandom), rd, er);
      end

      // Zero-wait instance: valid held high -> accept every second cycle.
      @(negedge clk);
      z_valid = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_wdata = 32'h55; z_sw = 2'b00;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("z_ready", 32'(z_ready), 32'(i % 2));
         chk("z_rsp_valid", 32'(z_rsp_valid), 32'(1 - i % 2));
         if (z_rsp_valid) pulses++;
      end
      chk("z_pulses", 32'(pulses), 32'd4);
      z_sw = 2'b11; z_wdata = 32'h99;
      @(negedge clk);
      chk("z_rsvd_valid", 32'(z_rsp_valid), 32'd1);
      chk("z_rsvd_err", 32'(z_rsp_err), 32'd1);
      z_we = 1'b0; z_lw = 3'd0;
      @(negedge clk);
      chk("z_idle_gap", 32'(z_rsp_valid), 32'd0);
      @(negedge clk);
      z_valid = 1'b0;
      chk("z_load_valid", 32'(z_rsp_valid), 32'd1);
      chk("z_load_rdata", z_rsp_rdata, 32'h55);
      chk("z_load_err", 32'(z_rsp_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the memory-side end of the load/store control produced by the instruction decoder (store width select, load width/extension select, memory write).
- Accepts one load or store request per transaction over a valid/ready handshake and waits a programmable number of cycles to model memory access time.
- Performs byte-lane merges for SW/SH/SB and extracts and extends loaded data for LW/LH/LHU/LB/LBU.
- Returns a one-cycle response pulse to the datapath.

Parameters:
- ADDR_W, 10: word-address bits; memory depth is 2**ADDR_W words of 32 bits.
- WAIT_CYC, 2: access wait cycles between accept and response; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the operand occupies the low bits.
- req_storewhb  input  2  00 SW, 01 SH, 10 SB, 11 reserved.
- req_loadwhb  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101..111 reserved.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, registered and held between responses.
- rsp_err  output  1  request rejected; valid with rsp_valid, held between responses.

Behaviour:
- Reset: asynchronous, active-high.
  - FSM goes to IDLE, wait counter clears.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 (combinational from IDLE once rst releases).
  - Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid is high at a clock edge, latch we/addr/wdata/storewhb/loadwhb and load the counter with WAIT_CYC. Go to WAIT if WAIT_CYC>0, else go directly to RESP.
  - WAIT: decrement the counter each cycle; go to RESP on the edge where the counter is 1.
  - RESP: rsp_valid=1 for exactly this cycle. Always return to IDLE next cycle.
  - req_ready=0 in WAIT and RESP. Inputs outside an accept edge are ignored.
- Latency and throughput:
  - Accept edge at cycle T; rsp_valid is high in cycle T+WAIT_CYC+1.
  - Next accept is possible at the earliest in cycle T+WAIT_CYC+2.
  - rsp_valid has no backpressure.
- Addressing:
  - Word index = addr[ADDR_W+1:2]; higher address bits are ignored (wrap).
  - Little-endian lanes: addr[1:0]=0 selects bits 7:0; addr[1]=0 selects the low half.
- Store, committed on the edge entering RESP:
  - SW: whole word written.
  - SH: wdata[15:0] written to the half selected by addr[1]; other half unchanged.
  - SB: wdata[7:0] written to the lane selected by addr[1:0]; other bytes unchanged.
  - rsp_rdata=0 on a store response.
- Load, read on the edge entering RESP and registered into rsp_rdata:
  - LW: whole word.
  - LH: selected half, sign-extended. LHU: selected half, zero-extended.
  - LB: selected byte, sign-extended. LBU: selected byte, zero-extended.
- Errors:
  - Reserved width encodings give rsp_err=1, rsp_rdata=0, and no write.
  - A valid request gives rsp_err=0.
- Reset mid-operation: the transaction is aborted and no response is issued. A store is not written unless the RESP-entry edge already occurred.
- Simultaneous events: a rst assertion on the RESP-entry edge wins, so no write occurs.

Optional Feature:
- Macro: DM_MISALIGN_CHK_EN.
- Defined:
  - SW/LW with addr[1:0]!=0, or SH/LH/LHU with addr[0]=1, are misaligned.
  - A misaligned request takes normal latency, then responds with rsp_err=1, rsp_rdata=0, and no memory write.
- Undefined:
  - No alignment check; the offending low address bits are treated as 0 (word/half forced aligned).
  - rsp_err is asserted only for reserved encodings.

Test Plan:
- Reset and latency, WAIT_CYC=2: hold rst, check req_ready=1, rsp_valid=0, rsp_rdata=0. Release, then SW addr 0x10 wdata 0xDEADBEEF accepted at T -> rsp_valid only at T+3, rsp_err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte/half merge: preload word 0x11223344 at 0x20. SB 0x21 wdata 0xAA, then SH 0x22 wdata 0x5566 -> LW 0x20 returns 0x5566AA44.
- Extension: word 0x80FF7F01 at 0x30.
  - LB 0x32 -> 0xFFFFFFFF; LBU 0x32 -> 0x000000FF.
  - LH 0x32 -> 0xFFFF80FF; LHU 0x30 -> 0x00007F01; LB 0x30 -> 0x00000001.
- Handshake and WAIT_CYC=0: req_valid held high continuously -> accepts every 2 cycles, req_ready=0 in RESP, one rsp_valid per accept. storewhb=11 store -> rsp_err=1, memory unchanged.
- Reset mid-op: SW 0x40 wdata 0x12345678 over old 0, assert rst during WAIT -> no rsp_valid; LW 0x40 returns 0.
- Misalign with DM_MISALIGN_CHK_EN: SH 0x41 -> rsp_err=1, memory unchanged. Without the macro, the same store writes the low half of word 0x40.
